// File: rtl/interrupt_unit.sv
// Interrupt unit: edge-detected pending bits, mask/pending/cause IO registers and
// a REQ/SERVICE handshake with the control unit. Define INT_SYNC_EN to add a 2-flop input synchronizer.
`timescale 1ns/1ps

module interrupt_unit #(
  parameter logic [7:0] MASK_PORT  = 8'h30,
  parameter logic [7:0] PEND_PORT  = 8'h31,
  parameter logic [7:0] CAUSE_PORT = 8'h32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] INT_IN,
  input  logic       I_SET,
  input  logic       I_CLR,
  input  logic       INT_ACK,
  input  logic       IO_STRB,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  output logic       INT_CU,
  output logic       I_FLAG,
  output logic [7:0] IO_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e     state_q;
  logic       int_cu_q;
  logic [3:0] cause_q;     // {valid, idx}
  logic [7:0] mask_q,  mask_d;
  logic [7:0] pend_q,  pend_d;
  logic [7:0] prev_q;
  logic       i_flag_q, i_flag_d;

  logic [7:0] int_cond;
  logic [7:0] rise;
  logic [7:0] active;
  logic [2:0] ack_idx;
  logic       irq_ready;
  logic       take_ack;
  logic       mask_wr;
  logic       pend_wr;
  logic [7:0] wr_clr;
  logic [7:0] ack_clr;

`ifdef INT_SYNC_EN
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= INT_IN;
      sync2_q <= sync1_q;
    end
  end

  assign int_cond = sync2_q;
`else
  assign int_cond = INT_IN;
`endif

  assign rise      = int_cond & ~prev_q;
  assign active    = pend_q & mask_q;
  assign irq_ready = i_flag_q && (|active);
  assign take_ack  = (state_q == ST_REQ) && irq_ready && INT_ACK;
  assign mask_wr   = IO_STRB && (PORT_ID == MASK_PORT);
  assign pend_wr   = IO_STRB && (PORT_ID == PEND_PORT);

  // Lowest set bit of the active vector is the highest-priority source.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    ack_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) ack_idx = 3'(i);
    end
  end

  always_comb begin
    wr_clr  = pend_wr  ? OUT_PORT : 8'h00;
    ack_clr = take_ack ? (8'h01 << ack_idx) : 8'h00;
    // A fresh edge overrides any clear landing on the same clock.
    pend_d  = (pend_q & ~wr_clr & ~ack_clr) | rise;
    mask_d  = mask_wr ? OUT_PORT : mask_q;
    if (I_CLR || INT_ACK) begin
      i_flag_d = 1'b0;
    end else if (I_SET) begin
      i_flag_d = 1'b1;
    end else begin
      i_flag_d = i_flag_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask_q   <= '0;
      pend_q   <= '0;
      prev_q   <= '0;
      i_flag_q <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      prev_q   <= int_cond;
      i_flag_q <= i_flag_d;
    end
  end

  // Request FSM; INT_CU is a flop written alongside the state so it has no input-to-output path.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      int_cu_q <= 1'b0;
      cause_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (irq_ready) begin
            state_q  <= ST_REQ;
            int_cu_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!irq_ready) begin
            state_q  <= ST_IDLE;
            int_cu_q <= 1'b0;
          end else if (INT_ACK) begin
            state_q  <= ST_SERVICE;
            int_cu_q <= 1'b0;
            cause_q  <= {1'b1, ack_idx};
          end
        end
        ST_SERVICE: begin
          int_cu_q <= 1'b0;
          if (I_SET) state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          int_cu_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    if (PORT_ID == MASK_PORT) begin
      IO_DATA = mask_q;
    end else if (PORT_ID == PEND_PORT) begin
      IO_DATA = pend_q;
    end else if (PORT_ID == CAUSE_PORT) begin
      IO_DATA = {cause_q[3], 4'b0000, cause_q[2:0]};
    end else begin
      IO_DATA = 8'h00;
    end
  end

  assign INT_CU = int_cu_q;
  assign I_FLAG = i_flag_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed scenarios plus a randomized run, all compared against a behavioural model of
// the interrupt unit (mask/pending/cause registers, I flag and request handshake).
`timescale 1ns/1ps

module tb_interrupt_unit;

`ifdef INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = SYNC_LAT + 2;

  localparam logic [7:0] MASK_P  = 8'h30;
  localparam logic [7:0] PEND_P  = 8'h31;
  localparam logic [7:0] CAUSE_P = 8'h32;
  localparam logic [7:0] OTHER_P = 8'h55;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] INT_IN;
  logic       I_SET, I_CLR, INT_ACK, IO_STRB;
  logic [7:0] PORT_ID, OUT_PORT;
  logic       INT_CU, I_FLAG;
  logic [7:0] IO_DATA;

  int tests = 0;
  int fails = 0;

  // Behavioural model state. m_state: 0 idle, 1 requesting, 2 in service.
  logic [7:0] m_mask, m_pend, m_cause, m_prev;
  logic       m_iflag;
  int         m_state;
  logic [7:0] m_dl[$];

  interrupt_unit #(
    .MASK_PORT (MASK_P),
    .PEND_PORT (PEND_P),
    .CAUSE_PORT(CAUSE_P)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .INT_IN  (INT_IN),
    .I_SET   (I_SET),
    .I_CLR   (I_CLR),
    .INT_ACK (INT_ACK),
    .IO_STRB (IO_STRB),
    .PORT_ID (PORT_ID),
    .OUT_PORT(OUT_PORT),
    .INT_CU  (INT_CU),
    .I_FLAG  (I_FLAG),
    .IO_DATA (IO_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] addr);
    if (addr == MASK_P)  return m_mask;
    if (addr == PEND_P)  return m_pend;
    if (addr == CAUSE_P) return m_cause;
    return 8'h00;
  endfunction

  // One clock: evaluate the model on the current inputs, take the edge, then compare.
  task automatic tick();
    logic [7:0] cond, rise, clr, act, n_mask, n_cause;
    int         n_state;
    logic       n_iflag;
    if (RESET) begin
      m_dl.delete();
      repeat (SYNC_LAT) m_dl.push_back(8'h00);
      m_mask = 0; m_pend = 0; m_cause = 0; m_prev = 0; m_iflag = 0; m_state = 0;
    end else begin
      m_dl.push_front(INT_IN);
      cond = m_dl[SYNC_LAT];
      void'(m_dl.pop_back());
      rise    = cond & ~m_prev;
      clr     = (IO_STRB && PORT_ID == PEND_P) ? OUT_PORT : 8'h00;
      n_mask  = (IO_STRB && PORT_ID == MASK_P) ? OUT_PORT : m_mask;
      act     = m_pend & m_mask;
      n_state = m_state;
      n_cause = m_cause;
      if (m_state == 0) begin
        if (m_iflag && act != 0) n_state = 1;
      end else if (m_state == 1) begin
        if (!m_iflag || act == 0) n_state = 0;
        else if (INT_ACK) begin
          int b = 0;
          while (!act[b]) b++;
          n_state = 2;
          n_cause = 8'h80 | 8'(b);
          clr     = clr | (8'h01 << b);
        end
      end else if (I_SET) begin
        n_state = 0;
      end
      n_iflag = (I_CLR || INT_ACK) ? 1'b0 : (I_SET ? 1'b1 : m_iflag);
      m_pend  = (m_pend & ~clr) | rise;
      m_prev  = cond;
      m_mask  = n_mask;
      m_cause = n_cause;
      m_iflag = n_iflag;
      m_state = n_state;
    end
    @(posedge CLK);
    #1;
    check("int_cu", {7'b0, INT_CU}, {7'b0, m_state == 1});
    check("i_flag", {7'b0, I_FLAG}, {7'b0, m_iflag});
    check("io_data", IO_DATA, model_read(PORT_ID));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    PORT_ID = addr;
    #1;
    check(tag, IO_DATA, exp);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    IO_STRB = 1'b1; PORT_ID = addr; OUT_PORT = data;
    tick();
    IO_STRB = 1'b0;
  endtask

  task automatic pulse_set();  I_SET = 1'b1;   tick(); I_SET = 1'b0;   endtask
  task automatic pulse_ack();  INT_ACK = 1'b1; tick(); INT_ACK = 1'b0; endtask

  initial begin
    RESET = 1'b1; INT_IN = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
    IO_STRB = 0; PORT_ID = OTHER_P; OUT_PORT = 0;
    repeat (SYNC_LAT) m_dl.push_back(8'h00);
    ticks(2);
    rd(MASK_P, 8'h00, "rst_mask");
    rd(PEND_P, 8'h00, "rst_pend");
    rd(CAUSE_P, 8'h00, "rst_cause");
    rd(OTHER_P, 8'h00, "other_port");
    RESET = 1'b0;
    tick();

    // Single source, priority 0
    wr(MASK_P, 8'h01);
    pulse_set();
    INT_IN = 8'h01;
    ticks(LAT - 1);
    check("lat_before", {7'b0, INT_CU}, 8'h00);
    tick();
    check("lat_at", {7'b0, INT_CU}, 8'h01);
    pulse_ack();
    rd(CAUSE_P, 8'h80, "cause_src0");
    rd(PEND_P, 8'h00, "pend_after_ack0");
    check("iflag_after_ack", {7'b0, I_FLAG}, 8'h00);
    pulse_set();
    INT_IN = 8'h00;
    ticks(SYNC_LAT + 1);

    // Two simultaneous sources: lowest index first
    wr(MASK_P, 8'hFF);
    INT_IN = 8'h24;
    ticks(LAT);
    check("req_two", {7'b0, INT_CU}, 8'h01);
    pulse_ack();
    rd(CAUSE_P, 8'h82, "cause_src2");
    rd(PEND_P, 8'h20, "pend_left5");
    pulse_set();
    tick();
    check("req_again", {7'b0, INT_CU}, 8'h01);
    pulse_ack();
    rd(CAUSE_P, 8'h85, "cause_src5");
    pulse_set();
    INT_IN = 8'h00;
    ticks(SYNC_LAT + 1);

    // Global flag gating and set/clear collision
    I_CLR = 1'b1; tick(); I_CLR = 1'b0;
    INT_IN = 8'h08;
    ticks(LAT);
    check("gated_no_req", {7'b0, INT_CU}, 8'h00);
    rd(PEND_P, 8'h08, "pend_gated");
    I_SET = 1'b1; I_CLR = 1'b1; tick(); I_CLR = 1'b0;
    check("clr_wins", {7'b0, I_FLAG}, 8'h00);
    tick(); I_SET = 1'b0;
    tick();
    check("req_after_set", {7'b0, INT_CU}, 8'h01);
    pulse_ack();
    rd(CAUSE_P, 8'h83, "cause_src3");
    pulse_set();
    INT_IN = 8'h00;
    ticks(SYNC_LAT + 1);

    // Write-1-to-clear racing a new edge
    wr(MASK_P, 8'h00);
    INT_IN = 8'h06;
    ticks(SYNC_LAT + 1);
    INT_IN = 8'h04;
    ticks(SYNC_LAT + 1);
    INT_IN = 8'h06;
    ticks(SYNC_LAT);
    wr(PEND_P, 8'h02);
    rd(PEND_P, 8'h06, "set_wins");
    wr(PEND_P, 8'h04);
    rd(PEND_P, 8'h02, "w1c");
    wr(PEND_P, 8'h02);
    INT_IN = 8'h00;
    ticks(SYNC_LAT + 1);

    // Request withdrawn by masking
    wr(MASK_P, 8'hFF);
    INT_IN = 8'h10;
    ticks(LAT);
    check("req_src4", {7'b0, INT_CU}, 8'h01);
    wr(MASK_P, 8'h00);
    tick();
    check("req_withdrawn", {7'b0, INT_CU}, 8'h00);
    rd(PEND_P, 8'h10, "pend_kept");

    // Reset in service, source held across release
    wr(MASK_P, 8'hFF);
    tick();
    pulse_ack();
    RESET = 1'b1; INT_IN = 8'h08;
    tick();
    rd(MASK_P, 8'h00, "rst_svc_mask");
    rd(PEND_P, 8'h00, "rst_svc_pend");
    rd(CAUSE_P, 8'h00, "rst_svc_cause");
    check("rst_svc_int_cu", {7'b0, INT_CU}, 8'h00);
    tick();
    RESET = 1'b0;
    ticks(LAT - 1);
    rd(PEND_P, 8'h08, "held_edge");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) INT_IN = 8'($urandom);
      I_SET   = ($urandom_range(0, 5) == 0);
      I_CLR   = ($urandom_range(0, 15) == 0);
      INT_ACK = ($urandom_range(0, 4) == 0);
      IO_STRB = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: PORT_ID = MASK_P;
        1: PORT_ID = PEND_P;
        2: PORT_ID = CAUSE_P;
        default: PORT_ID = OTHER_P;
      endcase
      OUT_PORT = 8'($urandom);
      RESET    = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_unit.md
INTERRUPT_UNIT -- requirements
Module: interrupt_unit

Interface
REQ-001 SHALL have parameter MASK_PORT, default 8'h30; IO port ID of the interrupt mask register (read/write).
REQ-002 SHALL have parameter PEND_PORT, default 8'h31; IO port ID of the pending register (read; write-1-to-clear).
REQ-003 SHALL have parameter CAUSE_PORT, default 8'h32; IO port ID of the cause register (read-only).
REQ-004 CLK  in  1  system clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 INT_IN  in  8  raw interrupt source levels; bit 0 is highest priority.
REQ-007 I_SET  in  1  control-unit SEI/RETIE strobe.
REQ-008 I_CLR  in  1  control-unit CLI/RETID/interrupt-entry strobe.
REQ-009 INT_ACK  in  1  high while the control unit is in its interrupt state.
REQ-010 IO_STRB  in  1  OUT-instruction write strobe.
REQ-011 PORT_ID  in  8  IO port address.
REQ-012 OUT_PORT  in  8  IO write data.
REQ-013 INT_CU  out  1  interrupt request to the control unit.
REQ-014 I_FLAG  out  1  global interrupt-enable flag.
REQ-015 IO_DATA  out  8  IO read data.

Function
REQ-016 Edge detect: bit i of PEND SHALL set on a clock where the conditioned INT_IN[i] is 1 and its previous sample is 0.
REQ-017 IO_STRB with PORT_ID==MASK_PORT SHALL load MASK<=OUT_PORT; with PORT_ID==PEND_PORT SHALL clear each PEND bit whose OUT_PORT bit is 1.
REQ-018 A PEND bit set and cleared on the same clock SHALL end up 1 (set wins).
REQ-019 I_FLAG SHALL set on I_SET and clear on I_CLR or INT_ACK; if both occur on one clock, clear wins.
REQ-020 FSM states are IDLE, REQ and SERVICE; INT_CU SHALL be 1 exactly when the state is REQ (registered, no combinational path).
REQ-021 IDLE->REQ when I_FLAG==1 and |(PEND & MASK)==1.
REQ-022 REQ->IDLE without acknowledge when I_FLAG drops or (PEND & MASK) becomes 0.
REQ-023 REQ->SERVICE on INT_ACK.
- CAUSE SHALL load {valid=1, idx} of the lowest set bit of PEND & MASK.
- That PEND bit SHALL clear; an edge on the same source in that clock re-sets it.
REQ-024 SERVICE->IDLE on I_SET; INT_CU stays 0 throughout SERVICE regardless of PEND.
REQ-025 IO_DATA SHALL be combinational from PORT_ID:
- MASK_PORT -> MASK
- PEND_PORT -> PEND
- CAUSE_PORT -> {valid, 4'b0, idx[2:0]}
- any other port -> 8'h00
REQ-026 Latency: INT_CU SHALL rise 2 clock edges after the first edge sampling INT_IN[i] high with the bit unmasked and I_FLAG=1; 4 edges with INT_SYNC_EN.

Reset
REQ-027 RESET=1 on a clock edge SHALL force the following, overriding all other inputs including mid-REQ and mid-SERVICE:
- MASK=0, PEND=0, CAUSE=0, I_FLAG=0
- previous-sample register and synchronizers = 0
- state=IDLE, INT_CU=0
REQ-028 A source already high when reset releases SHALL register one edge (previous sample resets to 0).

Configuration
REQ-029 With INT_SYNC_EN defined, each INT_IN bit SHALL pass through a two-flop synchronizer before edge detection; without it, INT_IN SHALL feed edge detection directly; the register map is identical in both builds.

Verification
REQ-030 MASK=8'h01, I_FLAG=1, INT_IN[0] 0->1 -> INT_CU=1 after 2 edges (4 with INT_SYNC_EN); INT_ACK -> CAUSE read = 8'h80, PEND=8'h00, I_FLAG=0.
REQ-031 MASK=8'hFF, INT_IN[5] and INT_IN[2] rise together, ack -> CAUSE=8'h82; PEND=8'h20; I_SET -> IDLE, then REQ again and ack -> CAUSE=8'h85.
REQ-032 Pending source with I_FLAG=0 -> INT_CU stays 0; I_SET and I_CLR on the same clock -> I_FLAG=0; a later I_SET -> INT_CU=1 on the next clock.
REQ-033 PEND=8'h06, OUT to PEND_PORT with 8'h02 while INT_IN[1] rises the same clock -> PEND=8'h06; OUT 8'h04 -> PEND=8'h02.
REQ-034 In REQ, MASK written to 8'h00 -> INT_CU drops next clock and the state returns to IDLE without acknowledge.
REQ-035 RESET asserted in SERVICE with MASK=8'hFF -> all registers read 8'h00 and INT_CU=0 the next clock; INT_IN[3] held high across reset release -> PEND=8'h08.
